// File: rtl/flow_key_matcher.sv
// Streaming flow-key matcher: compares a serially received key against a
// programmed rule under a per-chunk care mask and emits one verdict per key.
module flow_key_matcher #(
  parameter int CHUNK_W    = 2,
  parameter int NUM_CHUNKS = 8,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_wr_en,
  input  logic [IDX_W-1:0]   cfg_wr_idx,
  input  logic [CHUNK_W-1:0] cfg_wr_data,
  input  logic [CHUNK_W-1:0] cfg_wr_mask,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_match,
  output logic               res_len_err,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; a producer holds its payload stable until that edge.
  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   chunk_idx;
  logic               acc, ovf;
  logic [CHUNK_W-1:0] rule [NUM_CHUNKS];
  logic [CHUNK_W-1:0] mask [NUM_CHUNKS];
  logic               accept, hit, eff_hit, at_end, len_err_now;

  assign accept      = in_valid && in_ready;
  assign at_end      = (chunk_idx == IDX_W'(NUM_CHUNKS - 1));
  assign hit         = ((in_data ^ rule[chunk_idx]) & mask[chunk_idx]) == '0;
  // Chunks past the end of an oversized key are discarded, not compared.
  assign eff_hit     = ovf ? 1'b1 : hit;
  assign len_err_now = ovf || !at_end;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (accept && in_last) next_state = RESULT;
      RESULT:  if (res_ready)         next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      COLLECT: in_ready  = rst_n;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        rule[i] <= '0;
        mask[i] <= '0;
      end
    end else if (cfg_wr_en && (32'(cfg_wr_idx) < NUM_CHUNKS)) begin
      rule[cfg_wr_idx] <= cfg_wr_data;
      mask[cfg_wr_idx] <= cfg_wr_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_idx   <= '0;
      acc         <= 1'b1;
      ovf         <= 1'b0;
      res_match   <= 1'b0;
      res_len_err <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        res_len_err <= len_err_now;
        res_match   <= acc && eff_hit && !len_err_now;
        chunk_idx   <= '0;
        acc         <= 1'b1;
        ovf         <= 1'b0;
      end else begin
        acc <= acc && eff_hit;
        if (at_end) ovf       <= 1'b1;
        else        chunk_idx <= chunk_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (state == RESULT && res_ready && res_match && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_flow_key_matcher.sv
// Directed bench for flow_key_matcher: table of keys with hand-computed
// verdicts plus hand-written stall, reset and config-race sequences.
module tb_flow_key_matcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_idx = '0;
  logic [1:0]  cfg_wr_data = '0;
  logic [1:0]  cfg_wr_mask = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_match;
  logic        res_len_err;
  logic [15:0] match_cnt;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_q[$];

  flow_key_matcher dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_mask(cfg_wr_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_len_err(res_len_err), .match_cnt(match_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] data, input logic [1:0] msk);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_data = data; cfg_wr_mask = msk;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Streams len chunks (chunk i = key[2i+:2]); optionally writes config on chunk 0.
  task automatic send_key(input string name, input logic [19:0] key, input int len,
                          input logic exp_match, input logic exp_err,
                          input logic cfg_on_first, input logic [2:0] cidx,
                          input logic [1:0] cdata, input logic [1:0] cmask);
    logic ready_ok;
    ready_ok = 1'b1;
    exp_q.push_back({exp_match, exp_err});
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cfg_wr_en = 1'b0;
      in_valid  = 1'b1;
      in_data   = key[2*i +: 2];
      in_last   = (i == len - 1);
      if (i == 0 && cfg_on_first) begin
        cfg_wr_en = 1'b1; cfg_wr_idx = cidx; cfg_wr_data = cdata; cfg_wr_mask = cmask;
      end
      if (!in_ready) ready_ok = 1'b0;
    end
    @(negedge clk);
    cfg_wr_en = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check({name, "_in_ready_all"}, 32'(ready_ok), 32'd1);
    check({name, "_res_valid_latency"}, 32'(res_valid), 32'd1);
  endtask

  task automatic get_result(input string name);
    logic [1:0] e;
    e = exp_q.pop_front();
    check({name, "_res_match"}, 32'(res_match), 32'(e[1]));
    check({name, "_res_len_err"}, 32'(res_len_err), 32'(e[0]));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (e[1] && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
    check({name, "_res_valid_drop"}, 32'(res_valid), 32'd0);
    check({name, "_match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
  endtask

  typedef struct {
    logic        cfg_en;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_data;
    logic [1:0]  cfg_mask;
    logic [19:0] key;
    int          len;
    logic        exp_match;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [1:0] rule_val[8];

  initial begin
    // rule chunks 0..7 = 01,10,11,00,01,10,11,00 -> packed key 16'h3939
    rule_val = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    vecs[0] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h03939, 8,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h03979, 8,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'd3, 2'b00, 2'b00, 20'h03979, 8,  1'b1, 1'b0};
    vecs[3] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h03939, 5,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h93939, 10, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h03938, 8,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h00001, 1,  1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 2'b00, 2'b00, 20'h03939, 8,  1'b1, 1'b0};

    // reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_match", 32'(res_match), 32'd0);
    check("rst_res_len_err", 32'(res_len_err), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // all-zero mask matches any correctly sized key
    send_key("zero_mask", 20'h0abcd, 8, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    get_result("zero_mask");

    for (int i = 0; i < 8; i++) cfg_write(3'(i), rule_val[i], 2'b11);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].cfg_en) cfg_write(vecs[v].cfg_idx, vecs[v].cfg_data, vecs[v].cfg_mask);
      send_key($sformatf("vec%0d", v), vecs[v].key, vecs[v].len,
               vecs[v].exp_match, vecs[v].exp_err, 1'b0, 3'd0, 2'b00, 2'b00);
      get_result($sformatf("vec%0d", v));
    end

    // result stall: outputs hold, no chunks consumed while in RESULT
    send_key("stall", 20'h03939, 8, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    in_valid = 1'b1; in_data = 2'b01; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_res_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("stall%0d_res_match", k), 32'(res_match), 32'd1);
      check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("stall");
    send_key("after_stall", 20'h03939, 8, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    get_result("after_stall");

    // config write racing chunk 0: old rule used, new rule for the next key
    send_key("race_old", 20'h03939, 8, 1'b1, 1'b0, 1'b1, 3'd0, 2'b11, 2'b11);
    get_result("race_old");
    send_key("race_new_old_key", 20'h03939, 8, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    get_result("race_new_old_key");
    send_key("race_new_key", 20'h0393b, 8, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    get_result("race_new_key");

    // reset mid-key after chunk 3
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = rule_val[i]; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_match_cnt", 32'(match_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_key("post_midrst", 20'h03939, 8, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
    get_result("post_midrst");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_key_matcher.md
Name: flow_key_matcher

Overview:
- Sequential, streaming counterpart of the combinational 2-bit comparator chain.
- Receives a packet flow key serially as CHUNK_W-bit chunks over a valid/ready stream.
- Compares each chunk against a programmed rule key under a per-chunk mask, and emits one match verdict per key over a valid/ready result interface.
- Sits between the header parser and the flow-table action logic.

Parameters:
CHUNK_W, 2, bits per key chunk
NUM_CHUNKS, 8, chunks per key (default key = 16 bits)
IDX_W, 3, width of chunk index (must hold NUM_CHUNKS-1)
CNT_W, 16, width of matched-packet counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_wr_en  input  1  write one rule chunk this cycle
cfg_wr_idx  input  IDX_W  chunk index to write
cfg_wr_data  input  CHUNK_W  rule value for that chunk
cfg_wr_mask  input  CHUNK_W  per-bit care mask (1 = compare, 0 = don't care)
in_valid  input  1  key chunk valid
in_ready  output  1  matcher can accept a chunk
in_data  input  CHUNK_W  key chunk, chunk 0 first
in_last  input  1  marks final chunk of key
res_valid  output  1  verdict valid
res_ready  input  1  downstream accepts verdict
res_match  output  1  key equals rule under mask
res_len_err  output  1  key length differed from NUM_CHUNKS
match_cnt  output  CNT_W  saturating count of accepted verdicts with res_match=1

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT, chunk_idx=0, acc=1, ovf=0.
  - All rule and mask registers = 0.
  - res_valid=0, res_match=0, res_len_err=0, match_cnt=0.
  - in_ready is 0 while rst_n=0 and 1 on the first cycle after release.
- Reset mid-packet or mid-result discards all in-flight state; the next accepted chunk is chunk 0 of a new key.
- Chunk acceptance happens on a cycle with in_valid & in_ready.
- States:
  - COLLECT: in_ready=1, res_valid=0.
  - RESULT: in_ready=0, res_valid=1; outputs held stable until res_ready.
- Per accepted chunk in COLLECT:
  - hit = ((in_data ^ rule[chunk_idx]) & mask[chunk_idx]) == 0.
  - acc <= acc & hit.
  - If chunk_idx == NUM_CHUNKS-1 and !in_last: set ovf=1, hold chunk_idx, and keep accepting and discarding chunks (no compare) until in_last.
  - Otherwise chunk_idx increments.
- Accepted chunk with in_last=1:
  - Go to RESULT next cycle.
  - res_len_err = ovf | (chunk_idx != NUM_CHUNKS-1).
  - res_match = acc_final & !res_len_err, where acc_final includes this chunk's hit.
  - chunk_idx=0, acc=1, ovf=0.
- Latency: verdict valid on the cycle after the last chunk is accepted.
  - Back-to-back keys: one bubble cycle minimum per key, because in_ready=0 while in RESULT.
- RESULT with res_ready=1:
  - Return to COLLECT next cycle; res_valid=0.
  - If res_match=1, match_cnt increments, saturating at all-ones.
- Config writes:
  - Take effect at the clock edge regardless of state.
  - A chunk compared on the same cycle as a write to its index uses the old rule/mask.
  - cfg_wr_idx >= NUM_CHUNKS is ignored.
- All-zero mask (reset default) matches any correctly sized key.
- Single-chunk key (in_last on chunk 0) with NUM_CHUNKS>1 → res_len_err=1, res_match=0.

Test Plan:
- Reset, then program rule chunks 0..7 = 2'b01,2'b10,2'b11,2'b00,2'b01,2'b10,2'b11,2'b00 with mask 2'b11. Stream the identical 8 chunks, in_last on chunk 7 → res_valid one cycle after the last accept, res_match=1, res_len_err=0; after res_ready, match_cnt=1.
- Same rule; stream a key with chunk 3 = 2'b01 → res_match=0, res_len_err=0, match_cnt unchanged.
- Set mask[3]=2'b00 and repeat the previous key → res_match=1.
- Stream 5 chunks with in_last on chunk 4 → res_len_err=1, res_match=0. Stream 10 chunks with in_last on chunk 9 → res_len_err=1, res_match=0, in_ready=1 throughout.
- Hold res_ready=0 for 4 cycles during RESULT → res_valid/res_match stable, in_ready=0, in_valid chunks not consumed. Assert rst_n=0 mid-key (after chunk 3) → res_valid=0 and match_cnt=0 immediately; the following full matching key yields res_match=1.
- Write rule[0] on the same cycle chunk 0 is accepted → verdict uses the old value; the next key uses the new value.
